// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one pipelined 32-bit adder with tag-routed results
//
// Purpose:
//   N_REQ requesters share a single non-stallable, valid-tagged pipelined adder.
//   A round-robin arbiter issues at most one operation per cycle. The issuing
//   requester's ID is pushed into a tag FIFO. Each adder result pops the head
//   tag and is returned to that requester one edge later. A drain state machine
//   blocks new issues and reports when the adder pipeline is empty.
//
// Ports:
//   clk, rstn           clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is combinational)
//   req_a/req_b/req_cin packed operands, requester i at [32*i+31:32*i]
//   rsp_valid           one-cycle result pulse to the owning requester
//   rsp_s/rsp_cout      shared result bus, holds its value between pulses
//   add_*               connection to the shared adder
//   drain_req/drained   quiesce request level / pipeline empty and halted
//   inflight            registered tag FIFO occupancy
//   err_orphan          sticky: adder result arrived with no outstanding tag
module adder_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*32-1:0]            req_a,
  input  logic [N_REQ*32-1:0]            req_b,
  input  logic [N_REQ-1:0]               req_cin,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [31:0]                    rsp_s,
  output logic                           rsp_cout,
  output logic [31:0]                    add_a,
  output logic [31:0]                    add_b,
  output logic                           add_cin,
  output logic                           add_valid_in,
  input  logic [31:0]                    add_s,
  input  logic                           add_cout,
  input  logic                           add_valid_out,
  input  logic                           drain_req,
  output logic                           drained,
  output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
  output logic                           err_orphan
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH+1);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Registered state
  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_s_q, rsp_s_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              drained_q, drained_d;
  logic              err_orphan_q, err_orphan_d;

  // Tag storage, no reset needed: only entries between rd and wr are ever read
  logic [ID_W-1:0]   tag_mem_q [TAG_DEPTH];

  // Combinational control
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic [ID_W-1:0]   head_tag;
  logic [N_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [ID_W:0]     search_idx;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = add_valid_out && !fifo_empty;
  assign head_tag   = tag_mem_q[rd_ptr_q];

  // A full FIFO can still accept a push in a cycle where a result pops the
  // head, which keeps throughput at one op per cycle when TAG_DEPTH equals
  // the adder latency.
  assign can_issue  = (state_q == ST_RUN) && (!fifo_full || add_valid_out);

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  // The index is one bit wider than ID_W so the wrap works for any N_REQ.
  always_comb begin
    grant_oh   = '0;
    grant_id   = '0;
    grant_any  = 1'b0;
    search_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      search_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (search_idx >= (ID_W+1)'(N_REQ)) begin
        search_idx = search_idx - (ID_W+1)'(N_REQ);
      end
      if (can_issue && !grant_any && req_valid[search_idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = search_idx[ID_W-1:0];
      end
    end
    if (grant_any) begin
      grant_oh[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant_oh;
  assign push      = grant_any;

  // Adder input mux; zeros when nothing transfers so the bus stays quiet.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        add_a   = req_a[32*i +: 32];
        add_b   = req_b[32*i +: 32];
        add_cin = req_cin[i];
      end
    end
  end

  assign add_valid_in = grant_any;

  // Next-state for pointers, occupancy and response registers
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    rsp_valid_d = '0;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    if (pop) begin
      rsp_valid_d[head_tag] = 1'b1;
      rsp_s_d               = add_s;
      rsp_cout_d            = add_cout;
    end

    // A result with no tag cannot be routed; it is dropped and flagged.
    err_orphan_d = err_orphan_q || (add_valid_out && fifo_empty);
  end

  // Drain FSM next state. An empty FIFO implies no pop this cycle, so the
  // empty test alone guarantees the adder holds no tracked operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)      state_d = ST_RUN;
        else if (fifo_empty) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_s_q      <= '0;
      rsp_cout_q   <= 1'b0;
      drained_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_s_q      <= rsp_s_d;
      rsp_cout_q   <= rsp_cout_d;
      drained_q    <= drained_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_id;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_cout   = rsp_cout_q;
  assign drained    = drained_q;
  assign inflight   = count_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter with stub pipelined adders
module tb_adder_share_arbiter;

  localparam int N     = 4;
  localparam int LAT   = 5;  // stub registers: valid_out rises after E4
  localparam int LAT_F = 6;  // slower stub for the small-FIFO instance

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [N-1:0]      req_valid, req_valid_f, req_ready, req_ready_f, req_cin;
  logic [N*32-1:0]   req_a, req_b;
  logic [N-1:0]      rsp_valid, rsp_valid_f;
  logic [31:0]       rsp_s, rsp_s_f, add_a, add_b, add_a_f, add_b_f, add_s, add_s_f;
  logic              rsp_cout, rsp_cout_f, add_cin, add_cin_f;
  logic              add_valid_in, add_valid_in_f, add_cout, add_cout_f;
  logic              add_valid_out, add_valid_out_f;
  logic              drain_req, drain_req_f, drained, drained_f, err_orphan, err_orphan_f;
  logic [3:0]        inflight;
  logic [2:0]        inflight_f;
  logic              stub_clr, inject_v;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t sbf_q[$];
  exp_t e;
  logic [N-1:0] grant_mask;
  bit   obs_rsp, obs_onehot;
  int   obs_id;

  adder_share_arbiter #(.N_REQ(N), .TAG_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_valid_in(add_valid_in),
    .add_s(add_s), .add_cout(add_cout), .add_valid_out(add_valid_out),
    .drain_req(drain_req), .drained(drained), .inflight(inflight), .err_orphan(err_orphan)
  );

  adder_share_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) dut_f (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid_f), .rsp_s(rsp_s_f), .rsp_cout(rsp_cout_f),
    .add_a(add_a_f), .add_b(add_b_f), .add_cin(add_cin_f), .add_valid_in(add_valid_in_f),
    .add_s(add_s_f), .add_cout(add_cout_f), .add_valid_out(add_valid_out_f),
    .drain_req(drain_req_f), .drained(drained_f), .inflight(inflight_f), .err_orphan(err_orphan_f)
  );

  // Stub adders: fixed-latency shift registers carrying {cout, sum}
  logic [LAT-1:0]         pv;
  logic [LAT-1:0][32:0]   pd;
  logic [LAT_F-1:0]       pvf;
  logic [LAT_F-1:0][32:0] pdf;

  always_ff @(posedge clk) begin
    if (stub_clr) begin
      pv  <= '0;
      pvf <= '0;
    end else begin
      pv  <= {pv[LAT-2:0], add_valid_in};
      pvf <= {pvf[LAT_F-2:0], add_valid_in_f};
    end
    pd  <= {pd[LAT-2:0], {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin)};
    pdf <= {pdf[LAT_F-2:0], {1'b0, add_a_f} + {1'b0, add_b_f} + 33'(add_cin_f)};
  end

  assign add_valid_out   = pv[LAT-1] | inject_v;
  assign add_s           = pd[LAT-1][31:0];
  assign add_cout        = pd[LAT-1][32];
  assign add_valid_out_f = pvf[LAT_F-1];
  assign add_s_f         = pdf[LAT_F-1][31:0];
  assign add_cout_f      = pdf[LAT_F-1][32];
  assign drain_req_f     = 1'b0;

  function automatic exp_t mk_exp(input int i);
    exp_t        x;
    logic [32:0] sum;
    sum  = {1'b0, req_a[32*i +: 32]} + {1'b0, req_b[32*i +: 32]} + 33'(req_cin[i]);
    x.id = i;
    x.s  = sum[31:0];
    x.c  = sum[32];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample point 3 time units after the edge: records transfers of the main
  // instance into the scoreboard and decodes its response bus.
  task automatic observe();
    #2;
    grant_mask = req_valid & req_ready;
    for (int i = 0; i < N; i++) if (grant_mask[i]) sb_q.push_back(mk_exp(i));
    obs_rsp    = |rsp_valid;
    obs_onehot = $onehot(rsp_valid);
    obs_id     = -1;
    for (int i = 0; i < N; i++) if (rsp_valid[i]) obs_id = i;
  endtask

  task automatic load(input int i);
    req_a[32*i +: 32] = $urandom;
    req_b[32*i +: 32] = $urandom;
    req_cin[i]        = 1'($urandom_range(0, 1));
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = c;
    req_valid[i]      = 1'b1;
  endtask

  task automatic apply_reset();
    rstn        = 1'b0;
    stub_clr    = 1'b1;
    req_valid   = '0;
    req_valid_f = '0;
    drain_req   = 1'b0;
    inject_v    = 1'b0;
    sb_q.delete();
    sbf_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn     = 1'b1;
    stub_clr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    observe();
    n_checks++;
    if (rsp_valid !== '0 || rsp_s !== 32'h0 || rsp_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b s=%h c=%b, required 0/0/0", rsp_valid, rsp_s, rsp_cout);
    end
    n_checks++;
    if (drained !== 1'b0 || err_orphan !== 1'b0 || inflight !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_status: drained=%b orphan=%b inflight=%0d, required 0/0/0", drained, err_orphan, inflight);
    end
    n_checks++;
    if (req_ready !== '0 || add_valid_in !== 1'b0 || add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_bus: ready=%b vin=%b a=%h b=%h cin=%b, required all 0", req_ready, add_valid_in, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_single_op();
    int lat;
    apply_reset();
    set_req(2, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    observe();
    n_checks++;
    if (req_ready !== 4'b0100 || add_valid_in !== 1'b1 || add_a !== 32'hFF || add_b !== 32'h1 || add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: ready=%b vin=%b a=%h b=%h cin=%b, required 0100/1/000000ff/00000001/0", req_ready, add_valid_in, add_a, add_b, add_cin);
    end
    step();
    req_valid = '0;
    lat = -1;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      observe();
      if (k == 0) begin
        n_checks++;
        if (inflight !== 4'd1) begin
          n_fail++;
          $display("FAIL single_inflight: inflight=%0d, required 1", inflight);
        end
      end
      if (obs_rsp) begin
        lat = k;
        n_checks++;
        e = sb_q.pop_front();
        if (rsp_valid !== 4'b0100 || rsp_s !== 32'h0000_0100 || rsp_cout !== 1'b0 || e.s !== 32'h100) begin
          n_fail++;
          $display("FAIL single_rsp: valid=%b s=%h c=%b, required 0100/00000100/0", rsp_valid, rsp_s, rsp_cout);
        end
      end
      if (lat < 0) step();
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL single_latency: response after edge %0d, required 5", lat);
    end
    step();
    observe();
    n_checks++;
    if (rsp_valid !== '0 || rsp_s !== 32'h0000_0100 || inflight !== 4'd0) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b s=%h inflight=%0d, required 0000/00000100/0", rsp_valid, rsp_s, inflight);
    end
  endtask

  task automatic test_round_robin();
    int n_iss, n_rsp, exp_g;
    logic [N-1:0] exp_oh;
    apply_reset();
    for (int i = 0; i < N; i++) load(i);
    req_valid = '1;
    n_iss = 0; n_rsp = 0; exp_g = 0;
    for (int c = 0; c < 60 && (n_iss < 12 || n_rsp < 12); c++) begin
      observe();
      if (n_iss < 12) begin
        exp_oh = '0;
        exp_oh[exp_g] = 1'b1;
        n_checks++;
        if (req_ready !== exp_oh) begin
          n_fail++;
          $display("FAIL rr_grant: issue %0d ready=%b, required %b", n_iss, req_ready, exp_oh);
        end
        exp_g = (exp_g + 1) % N;
        n_iss++;
      end
      if (n_rsp > 0 && n_rsp < 12) begin
        n_checks++;
        if (!obs_rsp) begin
          n_fail++;
          $display("FAIL rr_gap: no response after %0d responses, required one per cycle", n_rsp);
        end
      end
      if (obs_rsp) begin
        n_rsp++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_rsp: response id %0d with no outstanding issue, required none", obs_id);
        end else begin
          e = sb_q.pop_front();
          if (!obs_onehot || obs_id != e.id || rsp_s !== e.s || rsp_cout !== e.c) begin
            n_fail++;
            $display("FAIL rr_rsp: valid=%b s=%h c=%b, required id %0d s=%h c=%b", rsp_valid, rsp_s, rsp_cout, e.id, e.s, e.c);
          end
        end
      end
      step();
      for (int i = 0; i < N; i++) if (grant_mask[i]) load(i);
      if (n_iss >= 12) req_valid = '0;
    end
    n_checks++;
    if (n_rsp != 12 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_count: %0d responses, %0d outstanding, required 12 and 0", n_rsp, sb_q.size());
    end
  endtask

  task automatic test_carry();
    bit got;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    got = 0;
    for (int c = 0; c < 15 && !got; c++) begin
      observe();
      if (obs_rsp) begin
        got = 1;
        e = sb_q.pop_front();
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_s !== 32'h0 || rsp_cout !== 1'b1 || e.c !== 1'b1) begin
          n_fail++;
          $display("FAIL carry_rsp: valid=%b s=%h c=%b, required 0001/00000000/1", rsp_valid, rsp_s, rsp_cout);
        end
      end
      step();
      req_valid = req_valid & ~grant_mask;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL carry_timeout: no response in 15 cycles, required one");
    end
  endtask

  task automatic test_drain();
    int n_iss, n_rsp;
    bit done, got;
    apply_reset();
    for (int i = 0; i < N; i++) load(i);
    req_valid = '1;
    n_iss = 0;
    for (int c = 0; c < 10 && n_iss < 4; c++) begin
      observe();
      n_iss += $countones(grant_mask);
      if (n_iss == 4) drain_req = 1'b1;  // rises alongside the 4th grant
      step();
      req_valid = req_valid & ~grant_mask;
    end
    load(1);
    req_valid = 4'b0010;
    n_rsp = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      observe();
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++;
        $display("FAIL drain_block: ready=%b while draining, required 0000", req_ready);
      end
      if (obs_rsp) begin
        n_rsp++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_rsp: response id %0d with no outstanding issue, required none", obs_id);
        end else begin
          e = sb_q.pop_front();
          if (!obs_onehot || obs_id != e.id || rsp_s !== e.s || rsp_cout !== e.c) begin
            n_fail++;
            $display("FAIL drain_rsp: valid=%b s=%h c=%b, required id %0d s=%h c=%b", rsp_valid, rsp_s, rsp_cout, e.id, e.s, e.c);
          end
        end
        if (n_rsp == 4) begin
          n_checks++;
          if (inflight !== 4'd0 || drained !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_last_pop: inflight=%0d drained=%b, required 0/0", inflight, drained);
          end
          step();
          observe();
          n_checks++;
          if (drained !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL drain_halted: drained=%b ready=%b, required 1/0000", drained, req_ready);
          end
          done = 1;
        end
      end
      if (!done) step();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d of 4 responses seen, required 4", n_rsp);
    end
    step();
    drain_req = 1'b0;
    observe();
    n_checks++;
    if (drained !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL drain_release_same: drained=%b ready=%b, required 1/0000", drained, req_ready);
    end
    step();
    observe();
    n_checks++;
    if (drained !== 1'b0 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL drain_resume: drained=%b ready=%b, required 0/0010", drained, req_ready);
    end
    step();
    req_valid = '0;
    got = 0;
    for (int c = 0; c < 15 && !got; c++) begin
      observe();
      if (obs_rsp) begin
        got = 1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs_id != 1 || rsp_s !== e.s || rsp_cout !== e.c) begin
          n_fail++;
          $display("FAIL drain_resume_rsp: valid=%b s=%h, required id 1 s=%h", rsp_valid, rsp_s, e.s);
        end
      end
      step();
    end
  endtask

  task automatic test_fifo_full();
    int n_iss, n_rsp, stalls, resumes, rid;
    logic [N-1:0] gm;
    apply_reset();
    for (int i = 0; i < N; i++) load(i);
    req_valid_f = '1;
    n_iss = 0; n_rsp = 0; stalls = 0; resumes = 0;
    for (int c = 0; c < 300 && (n_iss < 24 || n_rsp < n_iss); c++) begin
      #2;
      gm = req_valid_f & req_ready_f;
      n_checks++;
      if (inflight_f > 3'd4) begin
        n_fail++;
        $display("FAIL full_bound: inflight=%0d, required <= 4", inflight_f);
      end
      if (inflight_f == 3'd4 && !add_valid_out_f) begin
        stalls++;
        n_checks++;
        if (req_ready_f !== '0) begin
          n_fail++;
          $display("FAIL full_stall: ready=%b with full FIFO and no pop, required 0000", req_ready_f);
        end
      end
      if (inflight_f == 3'd4 && add_valid_out_f && gm != '0) resumes++;
      for (int i = 0; i < N; i++) if (gm[i]) sbf_q.push_back(mk_exp(i));
      n_iss += $countones(gm);
      if (|rsp_valid_f) begin
        n_rsp++;
        rid = -1;
        for (int i = 0; i < N; i++) if (rsp_valid_f[i]) rid = i;
        n_checks++;
        if (sbf_q.size() == 0) begin
          n_fail++;
          $display("FAIL full_rsp: response id %0d with no outstanding issue, required none", rid);
        end else begin
          e = sbf_q.pop_front();
          if (!$onehot(rsp_valid_f) || rid != e.id || rsp_s_f !== e.s || rsp_cout_f !== e.c) begin
            n_fail++;
            $display("FAIL full_rsp: valid=%b s=%h c=%b, required id %0d s=%h c=%b", rsp_valid_f, rsp_s_f, rsp_cout_f, e.id, e.s, e.c);
          end
        end
      end
      step();
      for (int i = 0; i < N; i++) if (gm[i]) load(i);
      if (n_iss >= 24) req_valid_f = '0;
    end
    n_checks++;
    if (stalls == 0 || resumes == 0) begin
      n_fail++;
      $display("FAIL full_activity: stalls=%0d resumes=%0d, required both > 0", stalls, resumes);
    end
    n_checks++;
    if (n_rsp != n_iss || n_iss != 24 || sbf_q.size() != 0 || err_orphan_f !== 1'b0 || drained_f !== 1'b0) begin
      n_fail++;
      $display("FAIL full_count: issued=%0d rsp=%0d left=%0d orphan=%b, required 24/24/0/0", n_iss, n_rsp, sbf_q.size(), err_orphan_f);
    end
  endtask

  task automatic test_orphan();
    observe();
    n_checks++;
    if (err_orphan !== 1'b0 || inflight !== 4'd0) begin
      n_fail++;
      $display("FAIL orphan_pre: orphan=%b inflight=%0d, required 0/0", err_orphan, inflight);
    end
    inject_v = 1'b1;
    step();
    inject_v = 1'b0;
    observe();
    n_checks++;
    if (err_orphan !== 1'b1 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL orphan_set: orphan=%b valid=%b, required 1/0000", err_orphan, rsp_valid);
    end
    repeat (3) step();
    observe();
    n_checks++;
    if (err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL orphan_sticky: orphan=%b, required 1", err_orphan);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_orphan;
    for (int i = 0; i < N; i++) load(i);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      observe();
      step();
      for (int i = 0; i < N; i++) if (grant_mask[i]) load(i);
    end
    #2;
    n_checks++;
    if (inflight == 4'd0 || err_orphan !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: inflight=%0d orphan=%b, required nonzero/1", inflight, err_orphan);
    end
    rstn = 1'b0;
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== '0 || rsp_s !== 32'h0 || rsp_cout !== 1'b0 || inflight !== 4'd0 || err_orphan !== 1'b0 || drained !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: valid=%b s=%h c=%b inflight=%0d orphan=%b drained=%b, required all 0",
               rsp_valid, rsp_s, rsp_cout, inflight, err_orphan, drained);
    end
    #3;
    rstn = 1'b1;
    sb_q.delete();
    seen_orphan = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      observe();
      n_checks++;
      if (rsp_valid !== '0) begin
        n_fail++;
        $display("FAIL midreset_rsp: valid=%b after reset, required 0000", rsp_valid);
      end
      if (err_orphan === 1'b1) seen_orphan = 1;
    end
    n_checks++;
    if (!seen_orphan) begin
      n_fail++;
      $display("FAIL midreset_orphan: orphan never set by leftover results, required 1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; stub_clr = 1'b1; inject_v = 1'b0; drain_req = 1'b0;
    req_valid = '0; req_valid_f = '0; req_a = '0; req_b = '0; req_cin = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_carry();
    test_drain();
    test_fifo_full();
    test_orphan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
